// File: rtl/vx_alu_rsp_sched_pkg.sv
// Shared types and helpers for the ALU commit-response scheduler.
package vx_alu_rsp_sched_pkg;

   // Packet-lock state: free arbitration, or held by one requester mid-warp.
   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   // Requester index width; a single requester still needs one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_alu_rsp_sched_if.sv
// Commit-stream bundle: per-requester input side and merged output side.
interface vx_alu_rsp_sched_if #(
   parameter int NUM_REQS = 3,
   parameter int DATAW    = 64,
   parameter int SEL_W    = 2
);
   logic [NUM_REQS-1:0]       valid_in;
   logic [NUM_REQS-1:0]       ready_in;
   logic [NUM_REQS*DATAW-1:0] data_in;
   logic [NUM_REQS-1:0]       eop_in;
   logic                      valid_out;
   logic                      ready_out;
   logic [DATAW-1:0]          data_out;
   logic                      eop_out;
   logic [SEL_W-1:0]          sel_out;

   // Environment side: sub-units drive requests, gather stage drives ready_out.
   modport master (
      output valid_in, data_in, eop_in, ready_out,
      input  ready_in, valid_out, data_out, eop_out, sel_out
   );

   // Scheduler side.
   modport slave (
      input  valid_in, data_in, eop_in, ready_out,
      output ready_in, valid_out, data_out, eop_out, sel_out
   );
endinterface

// File: rtl/vx_alu_rsp_sched_buf.sv
// Two-entry output FIFO of {data, eop, sel}; the head entry is a register so
// the block's outputs come straight from flops.
module vx_rsp_sched_buf #(
   parameter int DATAW = 64,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [DATAW-1:0] data_i,
   input  logic             eop_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic [DATAW-1:0] data_o,
   output logic             eop_o,
   output logic [SEL_W-1:0] sel_o,
   output logic [1:0]       count_o,
   output logic             space_o
);
   localparam int EW = DATAW + 1 + SEL_W;

   logic [EW-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]    count_q, count_d;
   logic [EW-1:0] in_e;
   logic          do_push, do_pop;

   assign in_e    = {data_i, eop_i, sel_i};
   // A full buffer refuses pushes even when it is popped in the same cycle.
   assign do_push = push_i && (count_q != 2'd2);
   assign do_pop  = pop_i && (count_q != 2'd0);

   // Next-state: the head refills from the tail, or directly from the input.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      if (do_pop) begin
         if (count_q == 2'd2)
            head_d = tail_q;
         else if (do_push)
            head_d = in_e;
      end else if (do_push) begin
         if (count_q == 2'd0)
            head_d = in_e;
         else
            tail_d = in_e;
      end
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign {data_o, eop_o, sel_o} = head_q;
   assign count_o = count_q;
   assign space_o = (count_q != 2'd2);

endmodule

// File: rtl/vx_alu_rsp_sched.sv
// ALU commit-response scheduler: round-robin merge of sub-unit commit streams
// with warp packet locking, feeding a registered 2-entry output buffer.
module vx_alu_rsp_sched
   import vx_alu_rsp_sched_pkg::*;
#(
   parameter int NUM_REQS = 3,
   parameter int DATAW    = 64,
   parameter int PERF_W   = 32,
   parameter int SEL_W    = sel_width(NUM_REQS)
) (
   input  logic                   clk,
   input  logic                   reset,
   vx_alu_rsp_sched_if.slave      bus,
   output logic [PERF_W-1:0]      perf_stall
);
   lock_state_e       state_q, state_d;
   logic [SEL_W-1:0]  owner_q, owner_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PERF_W-1:0] perf_q;

   logic              grant_valid;
   logic [SEL_W-1:0]  grant;
   logic              space, push, pop, push_eop;
   logic [DATAW-1:0]  push_data;
   logic [1:0]        buf_count;

   // (base + off) mod NUM_REQS without assuming a power-of-two size.
   function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQS) s = s - NUM_REQS;
      return SEL_W'(s);
   endfunction

   // Grant: owner only while locked, else first valid requester from rr_ptr.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      if (state_q == ST_LOCKED) begin
         grant_valid = bus.valid_in[owner_q];
         grant       = owner_q;
      end else begin
         // Walk offsets downward so the smallest offset is the final winner.
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (bus.valid_in[rr_idx(rr_ptr_q, k)]) begin
               grant_valid = 1'b1;
               grant       = rr_idx(rr_ptr_q, k);
            end
         end
      end
   end

   assign push      = !reset && space && grant_valid;
   assign pop       = bus.valid_out && bus.ready_out;
   assign push_data = bus.data_in[int'(grant)*DATAW +: DATAW];
   assign push_eop  = bus.eop_in[grant];

   // One-hot ready toward the granted requester; held low during reset.
   always_comb begin
      bus.ready_in = '0;
      if (push) bus.ready_in[grant] = 1'b1;
   end

   // Lock FSM next state: a non-eop packet locks, an eop packet releases.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         if (!push_eop) begin
            state_d = ST_LOCKED;
            owner_d = grant;
         end else begin
            state_d  = ST_UNLOCKED;
            rr_ptr_d = rr_idx(grant, 1);
         end
      end
   end

   // Lock/pointer registers and the saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_UNLOCKED;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         perf_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         if (bus.valid_out && !bus.ready_out && (perf_q != {PERF_W{1'b1}}))
            perf_q <= perf_q + 1'b1;
      end
   end

   vx_rsp_sched_buf #(
      .DATAW (DATAW),
      .SEL_W (SEL_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_data),
      .eop_i   (push_eop),
      .sel_i   (grant),
      .data_o  (bus.data_out),
      .eop_o   (bus.eop_out),
      .sel_o   (bus.sel_out),
      .count_o (buf_count),
      .space_o (space)
   );

   assign bus.valid_out = (buf_count != 2'd0);
   assign perf_stall    = perf_q;

endmodule

// File: tb/tb_vx_alu_rsp_sched.sv
// Directed scoreboard bench for vx_alu_rsp_sched (3 requesters, 4-bit stall counter).
module tb_vx_alu_rsp_sched;
   localparam int N  = 3;
   localparam int DW = 64;
   localparam int PW = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] perf_stall;

   vx_alu_rsp_sched_if #(.NUM_REQS(N), .DATAW(DW), .SEL_W(SW)) bus ();

   vx_alu_rsp_sched #(.NUM_REQS(N), .DATAW(DW), .PERF_W(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .perf_stall (perf_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [DW-1:0] data; logic eop; logic [SW-1:0] sel; } pkt_t;
   typedef struct packed { logic [DW-1:0] data; logic eop; } req_t;

   pkt_t exp_q [$];
   req_t req_q [N][$];
   int   checks = 0;
   int   errors = 0;
   logic ro_nxt, rst_nxt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic void add(input int i, input logic [DW-1:0] d, input logic e);
      req_t r;
      r.data = d;
      r.eop  = e;
      req_q[i].push_back(r);
   endfunction

   function automatic void expect_pkt(input logic [DW-1:0] d, input logic e, input int s);
      pkt_t p;
      p.data = d;
      p.eop  = e;
      p.sel  = SW'(s);
      exp_q.push_back(p);
   endfunction

   // Called at a negedge: retire accepted packets at the next posedge, present
   // queue heads #1 later, then return at the following negedge.
   task automatic tick();
      logic [N-1:0] acc;
      acc = bus.valid_in & bus.ready_in;
      chk("ready_onehot0", 64'($onehot0(bus.ready_in)), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) void'(req_q[i].pop_front());
         if (req_q[i].size() > 0) begin
            bus.valid_in[i]           = 1'b1;
            bus.data_in[i*DW +: DW]   = req_q[i][0].data;
            bus.eop_in[i]             = req_q[i][0].eop;
         end else begin
            bus.valid_in[i]           = 1'b0;
            bus.data_in[i*DW +: DW]   = '0;
            bus.eop_in[i]             = 1'b0;
         end
      end
      reset         = rst_nxt;
      bus.ready_out = ro_nxt;
      @(negedge clk);
   endtask

   // Output scoreboard: every handshake must match the next expected packet.
   always @(negedge clk) begin
      if (!reset && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL out_unexpected: observed data 0x%0h, expected no output", bus.data_out);
         end
         if (exp_q.size() != 0) begin
            pkt_t p;
            p = exp_q.pop_front();
            chk("out_data", 64'(bus.data_out), 64'(p.data));
            chk("out_eop",  64'(bus.eop_out),  64'(p.eop));
            chk("out_sel",  64'(bus.sel_out),  64'(p.sel));
         end
      end
   end

   initial begin
      reset = 1'b1; bus.valid_in = '0; bus.data_in = '0; bus.eop_in = '0; bus.ready_out = 1'b1;
      rst_nxt = 1'b1; ro_nxt = 1'b1;
      @(negedge clk);

      // Reset state; req0 presents during reset and must not be accepted.
      add(0, 64'hEE, 1'b1);
      tick(); tick();
      chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst_data_out",  64'(bus.data_out),  64'd0);
      chk("rst_eop_out",   64'(bus.eop_out),   64'd0);
      chk("rst_sel_out",   64'(bus.sel_out),   64'd0);
      chk("rst_perf",      64'(perf_stall),    64'd0);
      chk("rst_ready_in",  64'(bus.ready_in),  64'd0);

      // Single packet from req1.
      rst_nxt = 1'b0;
      req_q[0].delete();
      add(1, 64'hA5, 1'b1); expect_pkt(64'hA5, 1'b1, 1);
      tick(); chk("single_ready", 64'(bus.ready_in), 64'b010);
      tick();
      chk("single_valid", 64'(bus.valid_out), 64'd1);
      chk("single_data",  64'(bus.data_out),  64'hA5);
      chk("single_sel",   64'(bus.sel_out),   64'd1);
      chk("single_eop",   64'(bus.eop_out),   64'd1);

      // Round-robin from rr_ptr=2, wrapping 2 -> 0, one packet per cycle.
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < N; i++) add(i, 64'(32'h1000 + 16*i + k), 1'b1);
      for (int j = 0; j < 12; j++) expect_pkt(64'(32'h1000 + 16*((2+j)%3) + j/3), 1'b1, (2+j)%3);
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("rr_ready", 64'(bus.ready_in), 64'(1 << ((2+j)%3)));
         if (j > 0) chk("rr_stream", 64'(bus.valid_out), 64'd1);
      end
      tick(); chk("rr_last_valid", 64'(bus.valid_out), 64'd1); chk("rr_idle_ready", 64'(bus.ready_in), 64'd0);
      tick(); chk("rr_drained", 64'(bus.valid_out), 64'd0);

      // Packet lock: req0 eop=0,0,1 leaves contiguously, others wait even while req0 idles.
      add(0, 64'h200, 1'b0); add(1, 64'h211, 1'b1); add(2, 64'h222, 1'b1);
      expect_pkt(64'h222, 1'b1, 2); expect_pkt(64'h200, 1'b0, 0); expect_pkt(64'h201, 1'b0, 0);
      expect_pkt(64'h202, 1'b1, 0); expect_pkt(64'h211, 1'b1, 1);
      tick(); chk("lock_a", 64'(bus.ready_in), 64'b100);
      tick(); chk("lock_b", 64'(bus.ready_in), 64'b001);
      tick(); chk("lock_idle_owner", 64'(bus.ready_in), 64'b000);
      add(0, 64'h201, 1'b0); add(0, 64'h202, 1'b1);
      tick(); chk("lock_d", 64'(bus.ready_in), 64'b001);
      tick(); chk("lock_e", 64'(bus.ready_in), 64'b001);
      tick(); chk("lock_release", 64'(bus.ready_in), 64'b010);
      tick(); chk("lock_idle", 64'(bus.ready_in), 64'b000);
      tick(); tick();

      // Backpressure: two packets buffer, ready drops when full, 5 stall cycles.
      chk("bp_perf0", 64'(perf_stall), 64'd0);
      ro_nxt = 1'b0;
      add(2, 64'h300, 1'b1); add(2, 64'h301, 1'b1); add(2, 64'h302, 1'b1);
      expect_pkt(64'h300, 1'b1, 2); expect_pkt(64'h301, 1'b1, 2); expect_pkt(64'h302, 1'b1, 2);
      tick(); chk("bp_ready1", 64'(bus.ready_in), 64'b100);
      tick(); chk("bp_ready2", 64'(bus.ready_in), 64'b100); chk("bp_valid", 64'(bus.valid_out), 64'd1);
      tick(); chk("bp_full", 64'(bus.ready_in), 64'd0); chk("bp_perf1", 64'(perf_stall), 64'd1);
      tick(); tick(); tick();
      chk("bp_perf4", 64'(perf_stall), 64'd4); chk("bp_full_hold", 64'(bus.ready_in), 64'd0);
      ro_nxt = 1'b1;
      tick();
      chk("bp_perf5", 64'(perf_stall), 64'd5);
      chk("bp_full_pop_noready", 64'(bus.ready_in), 64'd0);
      chk("bp_head0", 64'(bus.data_out), 64'h300);
      tick(); chk("bp_refill", 64'(bus.ready_in), 64'b100); chk("bp_head1", 64'(bus.data_out), 64'h301);
      tick(); chk("bp_head2", 64'(bus.data_out), 64'h302);
      tick(); chk("bp_empty", 64'(bus.valid_out), 64'd0); chk("bp_perf_hold", 64'(perf_stall), 64'd5);

      // Reset while locked to req1 with a full buffer.
      ro_nxt = 1'b0;
      add(1, 64'h400, 1'b0); add(1, 64'h401, 1'b0); add(1, 64'h402, 1'b0);
      tick(); chk("rml_ready1", 64'(bus.ready_in), 64'b010);
      tick(); chk("rml_ready2", 64'(bus.ready_in), 64'b010);
      tick(); chk("rml_full", 64'(bus.ready_in), 64'd0); chk("rml_valid", 64'(bus.valid_out), 64'd1);
      req_q[1].delete(); rst_nxt = 1'b1;
      tick(); chk("rml_rst_ready", 64'(bus.ready_in), 64'd0);
      rst_nxt = 1'b0; ro_nxt = 1'b1;
      add(2, 64'h4F0, 1'b1); expect_pkt(64'h4F0, 1'b1, 2);
      tick();
      chk("rml_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rml_perf", 64'(perf_stall), 64'd0);
      chk("rml_regrant", 64'(bus.ready_in), 64'b100);
      tick();
      chk("rml_out_valid", 64'(bus.valid_out), 64'd1);
      chk("rml_out_data", 64'(bus.data_out), 64'h4F0);
      chk("rml_out_sel", 64'(bus.sel_out), 64'd2);
      tick();

      // Stall counter saturation at 4 bits.
      ro_nxt = 1'b0;
      add(0, 64'h500, 1'b1); expect_pkt(64'h500, 1'b1, 0);
      tick(); chk("sat_ready", 64'(bus.ready_in), 64'b001);
      for (int n = 0; n < 20; n++) begin
         tick();
         if (n == 14) chk("sat_pre", 64'(perf_stall), 64'd14);
      end
      chk("sat_perf", 64'(perf_stall), 64'd15);
      ro_nxt = 1'b1;
      tick(); chk("sat_head", 64'(bus.data_out), 64'h500); chk("sat_hold", 64'(perf_stall), 64'd15);
      tick(); tick();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vx_alu_rsp_sched.md
Name: vx_alu_rsp_sched

Overview:
Per-block commit-response scheduler for the ALU cluster. It merges the commit streams of the ALU sub-units (integer, dot8, optional muldiv) into one per-block commit stream ahead of the gather stage.
- Round-robin fairness.
- Packet locking, so a warp split into several lane-packets (NUM_LANES < NUM_THREADS) leaves contiguously.
- Registered 2-entry output buffer, so no combinational ready path crosses the block.

Parameters:
NUM_REQS, 3, number of requesting sub-units (2 when M extension disabled); must be ≥1.
DATAW, 64, width of one commit payload.
PERF_W, 32, width of the stall performance counter.
SEL_W (derived), max(1, clog2(NUM_REQS)), width of the requester index.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  NUM_REQS  per-requester valid
ready_in  out  NUM_REQS  per-requester ready
data_in  in  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW]
eop_in  in  NUM_REQS  last packet of the warp instruction
valid_out  out  1  output valid
ready_out  in  1  downstream ready
data_out  out  DATAW  selected payload
eop_out  out  1  eop of the selected packet
sel_out  out  SEL_W  index of the requester that produced the head entry
perf_stall  out  PERF_W  saturating count of cycles with valid_out=1 and ready_out=0

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: buffer count=0, valid_out=0, data_out=0, eop_out=0, sel_out=0, lock=0, owner=0, rr_ptr=0, perf_stall=0, all ready_in=0 during the reset cycle.
- Buffer: 2-entry FIFO of {data, eop, sel}.
  - space = (count < 2), computed from registers only.
  - pop = valid_out && ready_out.
  - push = any ready_in[i] && valid_in[i].
  - Push and pop may occur in the same cycle; count is unchanged in that case.
  - No push when count==2, even if a pop happens that cycle.
- Head exposure: valid_out/data_out/eop_out/sel_out are driven directly from the head-entry registers.
- Latency and throughput:
  - Latency from accept to valid_out is 1 cycle.
  - Sustained throughput is 1 packet/cycle with ready_out held high.
- Grant, combinational from registered state:
  - Unlocked: scan the valid requesters starting at rr_ptr, wrapping modulo NUM_REQS; grant the first one found.
  - Locked: only the owner is eligible. Other requesters get ready_in=0 even if the owner is idle.
  - ready_in[i] = space && grant_valid && (grant==i). At most one ready_in is high per cycle.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED, accept from g with eop=0 -> LOCKED, owner=g. rr_ptr is unchanged.
  - UNLOCKED, accept from g with eop=1 -> stay UNLOCKED, rr_ptr=(g+1) mod NUM_REQS.
  - LOCKED, accept from owner with eop=0 -> stay LOCKED.
  - LOCKED, accept from owner with eop=1 -> UNLOCKED, rr_ptr=(owner+1) mod NUM_REQS.
- Wrap-around: with NUM_REQS=3, rr_ptr goes 2 -> 0. Pointer arithmetic must not rely on power-of-two sizes.
- Empty buffer: valid_out=0. The head registers hold their last values and are don't-care.
- Full buffer: all ready_in=0. Input data is ignored.
- perf_stall: increments when valid_out && !ready_out, and saturates at all-ones.
- Reset mid-operation: buffered packets are discarded and the lock is released. Requesters must re-present after reset. No partial packet is emitted.
- NUM_REQS=1: arbitration degenerates to a pass-through with buffering. sel_out is constant 0.
- Protocol assertions for verification:
  - A requester holding valid_in must keep data_in and eop_in stable until accepted.
  - ready_in must never have more than one bit set.

Decomposition:
- Shared package (VX_gpu_pkg): the DATAW composition of the commit payload (uuid, wid, tmask, PC, rd, wb, data, pid, sop, eop). The eop bit position is taken from it by the instantiating block.
- One natural sub-module: vx_rsp_sched_buf, the 2-entry FIFO holding {data, eop, sel} with count and space outputs.
- Arbitration and lock logic stay in the top module.

Test Plan:
- Single packet: reset, then req1 valid with eop=1, data=0xA5 -> ready_in=3'b010 that cycle; next cycle valid_out=1, data_out=0xA5, sel_out=1, eop_out=1; rr_ptr=2.
- Round-robin: all 3 requesters continuously valid, eop=1, ready_out=1 -> sel_out sequence 0,1,2,0,1,2; one packet per cycle after first.
- Lock: req0 sends eop=0,0,1 while req1 and req2 stay valid -> the three req0 packets leave back-to-back; req1 follows next; ready_in[1] and ready_in[2] stay 0 until req0's eop is accepted.
- Backpressure: ready_out=0 for 5 cycles with req2 valid -> 2 packets buffered; ready_in=0 after count==2; perf_stall=5 (counting from the first valid_out cycle); after release, both packets drain in order.
- Reset mid-lock: reset asserted while LOCKED(owner=1) with count=2 -> next cycle valid_out=0, count=0, lock=0, rr_ptr=0; req2 valid alone is granted immediately.
- Saturation: PERF_W=4, hold valid_out=1 and ready_out=0 for 20 cycles -> perf_stall stops at 15.
